// File: rtl/l1_sched_pkg.sv
// Shared types and defaults for the layer-1 input scheduler.
package l1_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_ADDR_W = 10;
    localparam int PIX_W      = 8;
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/l1_sched_skid.sv
// Two-entry output FIFO holding {last, data} between memory and the normalize stage.
module l1_sched_skid
    import l1_sched_pkg::*;
#(
    parameter int W = PIX_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         not_empty,
    output logic [1:0]   count
);

    logic [W-1:0] entry [SKID_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count_q;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok   = push && (count_q < 2'(SKID_DEPTH));
    assign pop_ok    = pop && (count_q != 2'd0);
    assign not_empty = (count_q != 2'd0);
    assign count     = count_q;
    assign head_data = not_empty ? entry[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; flush drops everything stored.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push_ok) entry[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/l1_input_scheduler.sv
// Raster-order image fetcher feeding the normalize stage with flow control.
// Optional macro L1_SCHED_PAD_EN adds a one-pixel zero border around the frame.
module l1_input_scheduler
    import l1_sched_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_last
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q;

    logic              issue;
    logic              slot_last;
    logic              launch;
    logic              abort_now;
    logic              pop;
    logic              credit_ok;
    logic [2:0]        occupancy;
    logic [PIX_W-1:0]  push_pixel;

    logic              fifo_valid;
    logic [PIX_W:0]    fifo_head;
    logic [1:0]        fifo_count;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign abort_now = abort && busy;
    assign launch    = (state_q == IDLE) && start && !abort && !rst;
    assign pop       = fifo_valid && pix_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (occupancy < 3'd2);

    assign pix_valid = fifo_valid;
    assign pix_data  = fifo_head[PIX_W-1:0];
    assign pix_last  = fifo_head[PIX_W];

`ifdef L1_SCHED_PAD_EN
    localparam int COL_W = $clog2(IMG_W + 2);
    localparam int ROW_W = $clog2(IMG_H + 2);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             border;
    logic             inflight_zero_q;

    assign border = (col_q == '0) || (col_q == COL_W'(IMG_W + 1)) ||
                    (row_q == '0) || (row_q == ROW_W'(IMG_H + 1));
    assign slot_last  = (col_q == COL_W'(IMG_W + 1)) && (row_q == ROW_W'(IMG_H + 1));
    assign mem_rd_en  = issue && !border;
    assign push_pixel = inflight_zero_q ? '0 : mem_rdata;

    // Output-frame position; border slots travel the pipe as zero pixels with no read.
    always_ff @(posedge clk) begin
        if (rst || abort_now) begin
            col_q           <= '0;
            row_q           <= '0;
            inflight_zero_q <= 1'b0;
        end else begin
            inflight_zero_q <= border;
            if (issue) begin
                if (col_q == COL_W'(IMG_W + 1)) begin
                    col_q <= '0;
                    row_q <= slot_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end
`else
    assign slot_last  = (addr_q == LAST_ADDR);
    assign mem_rd_en  = issue;
    assign push_pixel = mem_rdata;
`endif

    // Next-state and slot-issue decision; abort wins over everything but reset.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    issue   = 1'b1;
                    state_d = slot_last ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (slot_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pop && fifo_head[PIX_W]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) issue = 1'b0;
    end

    // State, read address counter, in-flight tracking and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= slot_last;
            done_q          <= (state_q == DRAIN) && !abort && pop && fifo_head[PIX_W];
            if (abort_now) begin
                addr_q <= '0;
            end else if (mem_rd_en) begin
                addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end
        end
    end

    l1_sched_skid #(
        .W(PIX_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort_now),
        .push      (inflight_q && !abort_now),
        .push_data ({inflight_last_q, push_pixel}),
        .pop       (pop),
        .head_data (fifo_head),
        .not_empty (fifo_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_l1_input_scheduler.sv
// Directed self-checking bench for l1_input_scheduler (honours L1_SCHED_PAD_EN).
module tb_l1_input_scheduler;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int ADDR_W = 10;
    localparam int NREAD  = IMG_W * IMG_H;
`ifdef L1_SCHED_PAD_EN
    localparam int FRAME_PIX = (IMG_W + 2) * (IMG_H + 2);
`else
    localparam int FRAME_PIX = NREAD;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_data;
    logic              pix_last;

    int compared   = 0;
    int mismatched = 0;

    l1_input_scheduler #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_last  (pix_last)
    );

    always #5 clk = ~clk;

    // Image memory model: each word holds the low byte of its address, one-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_addr[7:0];
    end

    task automatic applyStimulus(input logic rdy, input logic st, input logic ab, input logic rs);
        pix_ready = rdy;
        start     = st;
        abort     = ab;
        rst       = rs;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] expPixel(input int k);
        logic lst;
        int   a;
        lst = (k == FRAME_PIX - 1);
`ifdef L1_SCHED_PAD_EN
        begin
            int r;
            int c;
            r = k / (IMG_W + 2);
            c = k % (IMG_W + 2);
            if (r == 0 || r == IMG_H + 1 || c == 0 || c == IMG_W + 1) return {lst, 8'h00};
            a = (r - 1) * IMG_W + (c - 1);
        end
`else
        a = k;
`endif
        return {lst, a[7:0]};
    endfunction

    // One frame: optional random ready, cut (abort or reset) at a pixel index, extra start pulse.
    task automatic runFrame(input bit rand_ready, input int cut_at, input bit use_rst, input int restart_at);
        int         k = 0;
        int         reads = 0;
        int         cyc = 0;
        bit         stalled = 0;
        bit         finished = 0;
        bit         cut = 0;
        bit         restarted = 0;
        logic [8:0] held = '0;
        logic       rdy;
        logic       st;
        logic       ab;
        logic       rs;
        while (!finished && !cut && cyc < 5000) begin
            @(posedge clk); #1;
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            st  = (cyc == 0);
            if (restart_at >= 0 && k == restart_at && !restarted) begin
                st        = 1'b1;
                restarted = 1;
            end
            ab = 1'b0;
            rs = 1'b0;
            if (cut_at >= 0 && k == cut_at) begin
                if (use_rst) rs = 1'b1;
                else         ab = 1'b1;
                cut = 1;
            end
            applyStimulus(rdy, st, ab, rs);
            @(negedge clk);
            if (mem_rd_en) reads++;
            if (cyc == 0) begin
                checkOutput("start_addr", 32'(mem_addr), 0);
                checkOutput("start_no_valid", 32'(pix_valid), 0);
            end
            if (cyc == 2 && !rand_ready) checkOutput("first_valid_latency", 32'(pix_valid), 1);
            if (stalled) begin
                checkOutput("stall_valid", 32'(pix_valid), 1);
                checkOutput("stall_hold", 32'({pix_last, pix_data}), 32'(held));
            end
            if (pix_valid && rdy) begin
                checkOutput("pixel", 32'({pix_last, pix_data}), 32'(expPixel(k)));
                if (k == FRAME_PIX - 1) finished = 1;
                k++;
            end
            stalled = pix_valid && !rdy;
            held    = {pix_last, pix_data};
            cyc++;
        end
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        if (cut) begin
            checkOutput("cut_valid", 32'(pix_valid), 0);
            checkOutput("cut_busy", 32'(busy), 0);
            checkOutput("cut_done", 32'(done), 0);
            if (use_rst) begin
                checkOutput("rst_rd_en", 32'(mem_rd_en), 0);
                checkOutput("rst_addr", 32'(mem_addr), 0);
                checkOutput("rst_data", 32'(pix_data), 0);
                checkOutput("rst_last", 32'(pix_last), 0);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("cut_no_late_done", 32'(done), 0);
        end else begin
            checkOutput("frame_completed", 32'(finished), 1);
            checkOutput("done_pulse", 32'(done), 1);
            checkOutput("busy_fall", 32'(busy), 0);
            checkOutput("end_valid", 32'(pix_valid), 0);
            checkOutput("pixel_count", 32'(k), 32'(FRAME_PIX));
            checkOutput("read_count", 32'(reads), 32'(NREAD));
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("done_single", 32'(done), 0);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_rd_en", 32'(mem_rd_en), 0);
        checkOutput("reset_addr", 32'(mem_addr), 0);
        checkOutput("reset_valid", 32'(pix_valid), 0);
        checkOutput("reset_data", 32'(pix_data), 0);
        checkOutput("reset_last", 32'(pix_last), 0);

        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("idle_abort_busy", 32'(busy), 0);

        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("abort_start_rd_en", 32'(mem_rd_en), 0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort_start_busy", 32'(busy), 0);

        $display("[TB] full frame, continuous ready");
        runFrame(1'b0, -1, 1'b0, -1);
        $display("[TB] full frame, random ready");
        runFrame(1'b1, -1, 1'b0, -1);
        $display("[TB] abort at pixel 100");
        runFrame(1'b0, 100, 1'b0, -1);
        $display("[TB] full frame after abort");
        runFrame(1'b0, -1, 1'b0, -1);
        $display("[TB] extra start at pixel 50, random ready");
        runFrame(1'b1, -1, 1'b0, 50);
        $display("[TB] reset at pixel 200");
        runFrame(1'b0, 200, 1'b1, -1);
        $display("[TB] full frame after reset");
        runFrame(1'b0, -1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
